clock_set_ctrl: RTL and testbench



---
 rtl/clock_pkg.sv | 33 +++
 rtl/clock_set_ctrl_if.sv | 25 ++
 rtl/btn_edge.sv | 32 +++
 rtl/clock_set_ctrl.sv | 144 ++++++++++++++
 tb/tb_clock_set_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the clock-calendar mode/set controller: state codes,
// blank-mask field indices, default timing and the state-to-field decode.
package clock_pkg;

  localparam logic [2:0] ST_RUN       = 3'd0;
  localparam logic [2:0] ST_SET_MIN   = 3'd1;
  localparam logic [2:0] ST_SET_HOUR  = 3'd2;
  localparam logic [2:0] ST_SET_DAY   = 3'd3;
  localparam logic [2:0] ST_SET_MONTH = 3'd4;

  localparam int FLD_MIN   = 0;
  localparam int FLD_HOUR  = 1;
  localparam int FLD_DAY   = 2;
  localparam int FLD_MONTH = 3;

  localparam int BLINK_DIV_DEF = 50;
  localparam int TIMEOUT_S_DEF = 10;

  // One-hot field selected by a SET state; all zero in RUN and unused codes.
  function automatic logic [3:0] fld_onehot(input logic [2:0] st);
    logic [3:0] oh;
    oh = '0;
    case (st)
      ST_SET_MIN:   oh[FLD_MIN]   = 1'b1;
      ST_SET_HOUR:  oh[FLD_HOUR]  = 1'b1;
      ST_SET_DAY:   oh[FLD_DAY]   = 1'b1;
      ST_SET_MONTH: oh[FLD_MONTH] = 1'b1;
      default:      oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Counter-chain bundle: terminal-count flags from the counters, enables,
// seconds clear and display blank mask back to them.
interface clock_set_ctrl_if;
  logic       sec_tc;
  logic       min_tc;
  logic       hour_tc;
  logic       day_tc;
  logic       ce_sec;
  logic       ce_min;
  logic       ce_hour;
  logic       ce_day;
  logic       ce_month;
  logic       sec_clr;
  logic [3:0] blank;

  modport master (
    input  sec_tc, min_tc, hour_tc, day_tc,
    output ce_sec, ce_min, ce_hour, ce_day, ce_month, sec_clr, blank
  );

  modport slave (
    output sec_tc, min_tc, hour_tc, day_tc,
    input  ce_sec, ce_min, ce_hour, ce_day, ce_month, sec_clr, blank
  );
endinterface

// File: rtl/btn_edge.sv
// Registers a debounced button level once and emits a one-cycle pulse on its
// rising edge; a held button yields a single pulse.
module btn_edge (
  input  logic clk,
  input  logic glob_rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic cur_q, cur_d;
  logic prev_q, prev_d;

  always_comb begin
    cur_d  = btn_i;
    prev_d = cur_q;
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (glob_rst) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  assign pulse_o = cur_q & ~prev_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the clock-calendar counter chain. Optional SET-mode
// auto-exit after TIMEOUT_S idle ticks is built when CLOCK_SET_AUTO_EXIT_EN is defined.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_DIV = BLINK_DIV_DEF,
  parameter int TIMEOUT_S = TIMEOUT_S_DEF
) (
  input  logic             clk,
  input  logic             glob_rst,
  input  logic             tick,
  input  logic             btn_mode,
  input  logic             btn_inc,
  clock_set_ctrl_if.master cnt,
  output logic [2:0]       mode
);

  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  if (BLINK_DIV < 2 || TIMEOUT_S < 1) begin : g_param_err
    $error("clock_set_ctrl: BLINK_DIV must be >= 2 and TIMEOUT_S >= 1");
  end

  logic          mode_pulse;
  logic          inc_pulse;
  logic          any_edge;
  logic          inc_ok;
  logic [3:0]    sel;
  logic [4:0]    ce_raw;
  logic          to_hit;

  logic [2:0]    state_q, state_d;
  logic          sec_clr_q, sec_clr_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  btn_edge u_mode_edge (
    .clk      (clk),
    .glob_rst (glob_rst),
    .btn_i    (btn_mode),
    .pulse_o  (mode_pulse)
  );

  btn_edge u_inc_edge (
    .clk      (clk),
    .glob_rst (glob_rst),
    .btn_i    (btn_inc),
    .pulse_o  (inc_pulse)
  );

  assign any_edge = mode_pulse | inc_pulse;
  // A simultaneous mode press swallows the increment.
  assign inc_ok   = inc_pulse & ~mode_pulse;
  assign sel      = fld_onehot(state_q);

`ifdef CLOCK_SET_AUTO_EXIT_EN
  localparam int TO_W = $clog2(TIMEOUT_S + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    to_hit   = 1'b0;
    if (state_q == ST_RUN || any_edge) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT_S)) begin
      to_cnt_d = '0;
      to_hit   = 1'b1;
    end else if (tick) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (glob_rst) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:       if (mode_pulse) state_d = ST_SET_MIN;
      ST_SET_MIN:   if (mode_pulse) state_d = ST_SET_HOUR;
      ST_SET_HOUR:  if (mode_pulse) state_d = ST_SET_DAY;
      ST_SET_DAY:   if (mode_pulse) state_d = ST_SET_MONTH;
      ST_SET_MONTH: if (mode_pulse) state_d = ST_RUN;
      default:      state_d = ST_RUN;
    endcase
    if (to_hit) state_d = ST_RUN;

    sec_clr_d = (state_q == ST_RUN) & mode_pulse;

    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (glob_rst) begin
      state_q     <= ST_RUN;
      sec_clr_q   <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_clr_q   <= sec_clr_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // ce_raw = {month, day, hour, min, sec}; RUN cascades tc flags off tick.
  always_comb begin
    ce_raw = '0;
    if (state_q == ST_RUN) begin
      ce_raw[0] = tick;
      ce_raw[1] = tick & cnt.sec_tc;
      ce_raw[2] = tick & cnt.sec_tc & cnt.min_tc;
      ce_raw[3] = tick & cnt.sec_tc & cnt.min_tc & cnt.hour_tc;
      ce_raw[4] = ce_raw[3] & cnt.day_tc;
    end else begin
      ce_raw[4:1] = sel & {4{inc_ok}};
    end
    if (glob_rst) ce_raw = '0;
  end

  assign cnt.ce_sec   = ce_raw[0];
  assign cnt.ce_min   = ce_raw[1];
  assign cnt.ce_hour  = ce_raw[2];
  assign cnt.ce_day   = ce_raw[3];
  assign cnt.ce_month = ce_raw[4];
  assign cnt.sec_clr  = sec_clr_q;
  assign cnt.blank    = sel & {4{phase_q}};
  assign mode         = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: RUN cascade table, mode cycling, set
// increments, blink, reset and (if built with it) the auto-exit timeout.
module tb_clock_set_ctrl;

  localparam int BLINK_DIV = 4;
  localparam int TIMEOUT_S = 3;

  logic       clk = 1'b0;
  logic       glob_rst;
  logic       tick;
  logic       btn_mode;
  logic       btn_inc;
  logic [2:0] mode;
  logic [4:0] ce_vec;

  int n_checks = 0;
  int n_err    = 0;

  clock_set_ctrl_if cif ();

  clock_set_ctrl #(
    .BLINK_DIV (BLINK_DIV),
    .TIMEOUT_S (TIMEOUT_S)
  ) dut (
    .clk      (clk),
    .glob_rst (glob_rst),
    .tick     (tick),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .cnt      (cif),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  assign ce_vec = {cif.ce_month, cif.ce_day, cif.ce_hour, cif.ce_min, cif.ce_sec};

  // Negedge monitors for events that span several cycles.
  bit         mon_clr = 1'b0;
  int         clr_cnt = 0;
  logic [2:0] clr_mode = '0;
  bit         mon_ce = 1'b0;
  bit         ce_seen = 1'b0;

  always @(negedge clk) begin
    if (mon_clr && cif.sec_clr) begin
      clr_cnt++;
      clr_mode = mode;
    end
    if (mon_ce && (ce_vec != 5'b0)) ce_seen = 1'b1;
  end

  typedef struct {
    logic       tick;
    logic       s_tc;
    logic       m_tc;
    logic       h_tc;
    logic       d_tc;
    logic [4:0] exp_ce;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit is_mode, input int hold);
    if (is_mode) btn_mode = 1'b1;
    else         btn_inc  = 1'b1;
    repeat (hold) nxt();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) nxt();
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    nxt();
    tick = 1'b0;
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic b[16];
    int   f;
    logic e;

    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'b00000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00001};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00011};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00111};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b01111};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'b11111};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00001};

    glob_rst = 1'b1;
    tick = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    cif.sec_tc = 1'b0;
    cif.min_tc = 1'b0;
    cif.hour_tc = 1'b0;
    cif.day_tc = 1'b0;

    // Reset: two cycles, ce held off even with tick high
    nxt();
    #3;
    check("rst_ce", 32'(ce_vec), 32'h0);
    nxt();
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_blank", 32'(cif.blank), 32'h0);
    check("rst_sec_clr", 32'(cif.sec_clr), 32'h0);
    glob_rst = 1'b0;
    #3;
    check("run_tick_ce_sec", 32'(ce_vec), 32'h1);
    nxt();
    tick = 1'b0;
    #3;
    check("run_notick_ce", 32'(ce_vec), 32'h0);
    nxt();

    // RUN cascade table
    for (int i = 0; i < 7; i++) begin
      tick        = vecs[i].tick;
      cif.sec_tc  = vecs[i].s_tc;
      cif.min_tc  = vecs[i].m_tc;
      cif.hour_tc = vecs[i].h_tc;
      cif.day_tc  = vecs[i].d_tc;
      #3;
      check($sformatf("cascade_vec%0d", i), 32'(ce_vec), 32'(vecs[i].exp_ce));
      check($sformatf("cascade_blank%0d", i), 32'(cif.blank), 32'h0);
      nxt();
    end
    tick = 1'b0;
    cif.sec_tc = 1'b0;
    cif.min_tc = 1'b0;
    cif.hour_tc = 1'b0;
    cif.day_tc = 1'b0;

    // Mode cycling 1,2,3,4,0 with a single sec_clr on SET_MIN entry
    mon_clr = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      press(1'b1, 1);
      check($sformatf("mode_seq%0d", i), 32'(mode), 32'(i % 5));
    end
    mon_clr = 1'b0;
    check("sec_clr_count", 32'(clr_cnt), 32'h1);
    check("sec_clr_on_set_min", 32'(clr_mode), 32'h1);

    press(1'b1, 20);
    check("mode_held20", 32'(mode), 32'h1);

    // SET_HOUR: each inc press gives one ce_hour one cycle after its edge
    press(1'b1, 1);
    check("mode_set_hour", 32'(mode), 32'h2);
    for (int i = 0; i < 3; i++) begin
      btn_inc = 1'b1;
      tick = 1'b1;
      #3;
      check($sformatf("inc%0d_pre", i), 32'(ce_vec), 32'h0);
      nxt();
      #3;
      check($sformatf("inc%0d_pulse", i), 32'(ce_vec), 32'b00100);
      nxt();
      tick = 1'b0;
      #3;
      check($sformatf("inc%0d_post", i), 32'(ce_vec), 32'h0);
      btn_inc = 1'b0;
      repeat (2) nxt();
    end

    // SET_MONTH blink: blank[3] toggles every BLINK_DIV cycles
    press(1'b1, 1);
    press(1'b1, 1);
    check("mode_set_month", 32'(mode), 32'h4);
    e = 1'b0;
    for (int j = 0; j < 16; j++) begin
      #3;
      b[j] = cif.blank[3];
      if (cif.blank[2:0] != 3'b0) e = 1'b1;
      nxt();
    end
    check("blink_low_bits", 32'(e), 32'h0);
    f = 0;
    for (int j = 1; j < 16; j++) begin
      if (f == 0 && b[j] != b[j-1]) f = j;
    end
    check("blink_first_toggle_seen", 32'((f >= 1) && (f <= BLINK_DIV)), 32'h1);
    if (f >= 1) begin
      for (int j = f; j < 16; j++) begin
        check($sformatf("blink_s%0d", j), 32'(b[j]), 32'(b[f] ^ (((j - f) / BLINK_DIV) % 2 == 1)));
      end
    end

    // Mode and inc together: state advances, no ce
    ce_seen = 1'b0;
    mon_ce = 1'b1;
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    repeat (2) nxt();
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (3) nxt();
    mon_ce = 1'b0;
    check("both_month_mode", 32'(mode), 32'h0);
    check("both_month_no_ce", 32'(ce_seen), 32'h0);
    press(1'b1, 1);
    ce_seen = 1'b0;
    mon_ce = 1'b1;
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    repeat (2) nxt();
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (3) nxt();
    mon_ce = 1'b0;
    check("both_min_mode", 32'(mode), 32'h2);
    check("both_min_no_ce", 32'(ce_seen), 32'h0);

    // Reset from SET_DAY
    press(1'b1, 1);
    check("mode_set_day", 32'(mode), 32'h3);
    glob_rst = 1'b1;
    tick = 1'b1;
    #3;
    check("midrst_ce", 32'(ce_vec), 32'h0);
    nxt();
    check("midrst_mode", 32'(mode), 32'h0);
    check("midrst_blank", 32'(cif.blank), 32'h0);
    check("midrst_sec_clr", 32'(cif.sec_clr), 32'h0);
    glob_rst = 1'b0;
    tick = 1'b0;
    nxt();

    // Idle ticks in SET_MIN: exit only when auto-exit is built in
    press(1'b1, 1);
    check("to_enter", 32'(mode), 32'h1);
    tick_pulse();
    tick_pulse();
    check("to_after2", 32'(mode), 32'h1);
    tick_pulse();
`ifdef CLOCK_SET_AUTO_EXIT_EN
    check("to_after3", 32'(mode), 32'h0);
    press(1'b1, 1);
`else
    check("to_after3", 32'(mode), 32'h1);
`endif
    tick_pulse();
    tick_pulse();
    press(1'b0, 1);
    tick_pulse();
    tick_pulse();
    check("to_restart_2", 32'(mode), 32'h1);
    tick_pulse();
`ifdef CLOCK_SET_AUTO_EXIT_EN
    check("to_restart_3", 32'(mode), 32'h0);
`else
    check("to_restart_3", 32'(mode), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
